// File: rtl/rv_core_pkg.sv
// Shared core definitions: data width, bubble encoding, instruction field
// positions and the fetch FSM state encoding.
package rv_core_pkg;

  localparam int          XLEN       = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_BIT = 30;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_resp_buf.sv
// One-entry skid buffer that parks a fetch response arriving while decode
// is stalled, so the outstanding transaction can retire.
module fetch_resp_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic            pop,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      instr <= 32'h0;
    end else if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage + IF/ID register. Optional IFETCH_MISALIGN_CHK_EN adds a
// sticky misalign_fault for unaligned redirect targets.
module instr_fetch_stage #(
  parameter int               XLEN      = rv_core_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            funct7
`ifdef IFETCH_MISALIGN_CHK_EN
  , output logic          misalign_fault
`endif
);
  import rv_core_pkg::*;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, req_pc;
  logic [XLEN-1:0] redir_tgt;
  logic            redir_bad, fault;
  logic            req_fire, rsp_take;
  logic            buf_valid, buf_load, buf_pop;
  logic [XLEN-1:0] buf_pc;
  logic [31:0]     buf_instr;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign redir_tgt = redirect_pc;
  assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst)            fault <= 1'b0;
    else if (redir_bad) fault <= 1'b1;
  end

  assign misalign_fault = fault;
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  assign redir_tgt = redirect_pc & ALIGN_MASK;
  assign redir_bad = 1'b0;
  assign fault     = 1'b0;
`endif

  assign imem_req_valid = !rst && (state == FETCH) && !stall && !redirect
                          && !buf_valid && !fault;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = (state == WAIT) && imem_rsp_valid;

  // A response that lands while decode is stalled is parked, never dropped.
  assign buf_load = !redirect && stall && rsp_take;
  assign buf_pop  = !redirect && !stall && buf_valid;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect) begin
      pc_nxt = redir_tgt;
      if (redir_bad)
        state_nxt = FETCH;
      else if (state == WAIT || state == DRAIN)
        state_nxt = imem_rsp_valid ? FETCH : DRAIN;
      else
        state_nxt = FETCH;
    end else begin
      case (state)
        FETCH: if (req_fire) begin
          state_nxt = WAIT;
          pc_nxt    = pc + XLEN'(4);
        end
        WAIT:    if (imem_rsp_valid) state_nxt = FETCH;
        DRAIN:   if (imem_rsp_valid) state_nxt = FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (req_fire) req_pc <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (!stall) begin
      if (buf_valid) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= buf_pc;
        if_id_instr <= buf_instr;
      end else if (rsp_take) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= req_pc;
        if_id_instr <= imem_rsp_data;
      end else begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

  fetch_resp_buf #(.XLEN(XLEN)) u_rsp_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (redirect),
    .load       (buf_load),
    .pop        (buf_pop),
    .load_pc    (req_pc),
    .load_instr (imem_rsp_data),
    .valid      (buf_valid),
    .pc         (buf_pc),
    .instr      (buf_instr)
  );

  assign opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];
  assign funct3 = if_id_instr[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7 = if_id_instr[FUNCT7_BIT];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a latency-programmable memory model,
// a scoreboard queue of expected IF/ID entries and a monitor that drains it.
module tb_instr_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        misalign_fault;
`endif

  instr_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
`ifdef IFETCH_MISALIGN_CHK_EN
    , .misalign_fault (misalign_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat   = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0000_0000: memf = 32'h0050_0093;  // addi x1,x0,5
      32'h0000_0004: memf = 32'h0020_81B3;  // add  x3,x1,x2
      32'h0000_0008: memf = 32'h00C0_0113;  // addi x2,x0,12 (must be drained)
      32'h0000_0100: memf = 32'h4020_8033;  // sub  x0,x1,x2
      32'hFFFF_FFFC: memf = 32'h0000_006F;  // jal  x0,0
      default:       memf = 32'hBAD0_0073;
    endcase
  endfunction

  // Memory model: request sampled late in a cycle, response 'lat' cycles later.
  logic        m_pend = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_addr = 32'h0;
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      if (rst) m_pend = 1'b0;
      else if (m_pend) begin
        if (m_cnt <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = memf(m_addr);
          m_pend = 1'b0;
        end else m_cnt--;
      end
      @(negedge clk); #3;
      if (!rst && imem_req_valid && imem_req_ready) begin
        m_pend = 1'b1;
        m_cnt  = lat;
        m_addr = imem_addr;
      end
    end
  end

  // Monitor: every newly loaded valid IF/ID entry must match the queue head.
  logic held;
  initial begin
    forever begin
      @(negedge clk); #3;
      held = (stall && !redirect) || rst;
      @(posedge clk); #1;
      if (!held && if_id_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected: got pc %h instr %h, required nothing", if_id_pc, if_id_instr);
        end else begin
          e = sb.pop_front();
          chk("sb_pc",     if_id_pc,             e.pc);
          chk("sb_instr",  if_id_instr,          e.instr);
          chk("sb_opcode", {25'h0, opcode},      {25'h0, e.instr[6:0]});
          chk("sb_funct3", {29'h0, funct3},      {29'h0, e.instr[14:12]});
          chk("sb_funct7", {31'h0, funct7},      {31'h0, e.instr[30]});
        end
      end
    end
  end

  task automatic push(input logic [31:0] pc);
    exp_t x;
    x.pc = pc; x.instr = memf(pc);
    sb.push_back(x);
  endtask

  task automatic wait_if_id(input logic [31:0] pc, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (if_id_valid && if_id_pc == pc) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: timeout, got pc %h required %h", name, if_id_pc, pc);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_if_valid",  {31'h0, if_id_valid},    32'h0);
    chk("rst_instr",     if_id_instr,             NOP);
    chk("rst_opcode",    {25'h0, opcode},         32'h13);
    chk("rst_funct3",    {29'h0, funct3},         32'h0);
    chk("rst_funct7",    {31'h0, funct7},         32'h0);
    chk("rst_if_pc",     if_id_pc,                32'h0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("first_req_addr",  imem_addr,               32'h0);
    push(32'h0);

    @(negedge clk);
    chk("wait_no_req", {31'h0, imem_req_valid}, 32'h0);
    @(negedge clk);
    chk("lat_if_valid", {31'h0, if_id_valid}, 32'h1);
    chk("lat_if_pc",    if_id_pc,             32'h0);
    chk("lat_opcode",   {25'h0, opcode},      32'h13);
    chk("lat_funct3",   {29'h0, funct3},      32'h0);
    chk("req2_addr",    imem_addr,            32'h4);
    push(32'h4);

    // Stall while the 0x4 fetch is outstanding: response must be buffered.
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    chk("stall_no_req",   {31'h0, imem_req_valid}, 32'h0);
    chk("stall_if_hold",  {31'h0, if_id_valid},    32'h0);
    chk("stall_if_instr", if_id_instr,             NOP);
    @(negedge clk);
    chk("stall_no_req2", {31'h0, imem_req_valid}, 32'h0);
    stall = 1'b0;
    #1;
    chk("buf_full_no_req", {31'h0, imem_req_valid}, 32'h0);
    @(negedge clk);
    chk("buf_instr",  if_id_instr,      32'h0020_81B3);
    chk("buf_opcode", {25'h0, opcode},  32'h33);
    chk("req3_addr",  imem_addr,        32'h8);
    lat = 2;

    // Redirect while the 0x8 fetch is outstanding.
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("drain_no_req", {31'h0, imem_req_valid}, 32'h0);
    chk("drain_pc",     imem_addr,               32'h100);
    @(negedge clk);
    chk("redir_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("redir_req_addr",  imem_addr,               32'h100);
    push(32'h100);

    // Redirect and stall together while IF/ID holds a valid instruction.
    wait_if_id(32'h100, "wait_0x100");
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("rs_if_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rs_if_instr", if_id_instr,          NOP);
    chk("rs_pc",       imem_addr,            32'hFFFF_FFFC);
    redirect = 1'b0; stall = 1'b0; lat = 1;
    #1;
    chk("wrap_req_valid", {31'h0, imem_req_valid}, 32'h1);
    push(32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc", imem_addr, 32'h0);
    @(negedge clk);
    chk("wrap_next_req", {31'h0, imem_req_valid}, 32'h1);
    chk("wrap_next_addr", imem_addr, 32'h0);
    push(32'h0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    chk("end_hold_valid", {31'h0, if_id_valid},    32'h1);
    chk("end_hold_pc",    if_id_pc,                32'h0);
    chk("end_no_req",     {31'h0, imem_req_valid}, 32'h0);

`ifdef IFETCH_MISALIGN_CHK_EN
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("mis_fault", {31'h0, misalign_fault}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mis_no_req", {31'h0, imem_req_valid}, 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mis_rst_clear", {31'h0, misalign_fault}, 32'h0);
`endif

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
